// File: rtl/sqrt_iter_if.sv
// rtl/sqrt_iter_if.sv - start/busy/done handshake bundle for the iterative square-root unit
interface sqrt_iter_if #(
    parameter int WIDTH = 16
);
    localparam int N = WIDTH / 2;

    logic             start;
    logic [WIDTH-1:0] radicand;
    logic [N-1:0]     root;
    logic [N:0]       remainder;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output radicand,
        input  root,
        input  remainder,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  radicand,
        output root,
        output remainder,
        output busy,
        output done
    );
endinterface

// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - iterative restoring integer square root, two radicand bits per clock
module sqrt_iter #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    sqrt_iter_if.slave  bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] opnd, opnd_n;
    logic [N+1:0]     p, p_n;
    logic [N-1:0]     q, q_n;
    logic [CW-1:0]    cnt, cnt_n;

    logic [N+1:0]     t;
    logic [N+1:0]     trial;
    logic [N+1:0]     d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            opnd  <= '0;
            p     <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            opnd  <= opnd_n;
            p     <= p_n;
            q     <= q_n;
            cnt   <= cnt_n;
        end
    end

    // Trial subtrahend is the current root shifted in as 4Q+1; everything stays N+2 bits wide.
    assign t     = {p[N-1:0], opnd[WIDTH-1 -: 2]};
    assign trial = {q, 2'b01};
    assign d     = t - trial;

    always_comb begin
        state_n = state;
        opnd_n  = opnd;
        p_n     = p;
        q_n     = q;
        cnt_n   = cnt;
        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.start) begin
                    opnd_n  = bus.radicand;
                    p_n     = '0;
                    q_n     = '0;
                    cnt_n   = CW'(N);
                    state_n = CALC;
                end
            end
            CALC: begin
                if (t >= trial) begin
                    p_n = d;
                    q_n = {q[N-2:0], 1'b1};
                end else begin
                    p_n = t;
                    q_n = {q[N-2:0], 1'b0};
                end
                opnd_n = {opnd[WIDTH-3:0], 2'b00};
                cnt_n  = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy      = (state == CALC);
    assign bus.done      = (state == DONE);
    assign bus.root      = q;
    assign bus.remainder = p[N:0];
endmodule
